// File: rtl/pipe_pkg.sv
// Shared decode constants, control bundle and ID/EXE record for the ID stage.
// Holds opcode/funct values, ALU op codes, the forwarding feedback bus type.
package pipe_pkg;

   localparam int PCW_DEF = 8;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_SRA = 6'b000011;
   localparam logic [5:0] FN_JR  = 6'b001000;
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_XOR = 6'b100110;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_LUI = 4'b0110;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1111;

   typedef struct packed {
      logic [3:0] aluc;
      logic       aluimm;
      logic       shift;
      logic       jal;
      logic       wreg;
      logic       m2reg;
      logic       wmem;
   } ctl_t;

   localparam ctl_t CTL_NOP = '0;

   typedef struct packed {
      ctl_t        ctl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [4:0]  sa;
      logic [4:0]  rn0;
   } id_ex_t;

   typedef struct packed {
      logic [4:0]  ern;
      logic        ewreg;
      logic        em2reg;
      logic [31:0] ealu;
      logic [4:0]  mrn;
      logic        mwreg;
      logic        mm2reg;
      logic [31:0] malu;
      logic [31:0] mmo;
   } fb_t;

   function automatic logic [31:0] ext16(
      input logic [15:0] v,
      input logic        s
   );
      return {{16{s & v[15]}}, v};
   endfunction

endpackage

// File: rtl/pipe_fwd_sel.sv
// Operand bypass mux: picks EXE result, MEM result/load data or RF read.
// Ports: src_i source reg, q_i RF value, fb_i EXE/MEM feedback, val_o operand.
module pipe_fwd_sel
   import pipe_pkg::*;
(
   input  logic [4:0]  src_i,
   input  logic [31:0] q_i,
   input  fb_t         fb_i,
   output logic [31:0] val_o
);

   logic nz;
   logic hit_e;
   logic hit_m;

   assign nz = (src_i != 5'd0);

   // A load in EXE has no data yet; that case is covered by the stall.
   assign hit_e = nz & fb_i.ewreg & ~fb_i.em2reg
                & (fb_i.ern == src_i);
   assign hit_m = nz & fb_i.mwreg & (fb_i.mrn == src_i);

   always_comb begin
      val_o = q_i;
      if (hit_e) begin
         val_o = fb_i.ealu;
      end else if (hit_m) begin
         val_o = fb_i.mm2reg ? fb_i.mmo : fb_i.malu;
      end
   end

endmodule

// File: rtl/pipe_id_ctrl.sv
// ID stage: decode, operand bypass, load-use stall, branch/jump resolve.
// Ports: IF/ID word+pc4, RF reads, EXE/MEM feedback in; PC ctrl, ID/EXE regs out.
module pipe_id_ctrl
   import pipe_pkg::*;
#(
   parameter int PCW = PCW_DEF
) (
   input  logic           clock,
   input  logic           reset,
   input  logic [31:0]    dinst,
   input  logic [PCW-1:0] dpc4,
   input  logic [31:0]    qa,
   input  logic [31:0]    qb,
   input  logic [4:0]     ern,
   input  logic           ewreg_fb,
   input  logic           em2reg_fb,
   input  logic [31:0]    ealu,
   input  logic [4:0]     mrn,
   input  logic           mwreg,
   input  logic           mm2reg,
   input  logic [31:0]    malu,
   input  logic [31:0]    mmo,
   output logic           wpcir,
   output logic [1:0]     pcsource,
   output logic [PCW-1:0] bpc,
   output logic [PCW-1:0] jpc,
   output logic [PCW-1:0] rpc,
   output logic [3:0]     ealuc,
   output logic           ealuimm,
   output logic           eshift,
   output logic           ejal,
   output logic           ewreg,
   output logic           em2reg,
   output logic           ewmem,
   output logic [31:0]    ea,
   output logic [31:0]    eb,
   output logic [31:0]    eimm,
   output logic [4:0]     esa,
   output logic [4:0]     ern0,
   output logic [PCW-1:0] epc4
);

   logic [5:0]  op;
   logic [5:0]  fn;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  sa;
   logic [15:0] imm16;

   assign op    = dinst[31:26];
   assign rs    = dinst[25:21];
   assign rt    = dinst[20:16];
   assign rd    = dinst[15:11];
   assign sa    = dinst[10:6];
   assign fn    = dinst[5:0];
   assign imm16 = dinst[15:0];

   ctl_t id_ctl;
   logic sext;
   logic regrt;
   logic use_rs;
   logic use_rt;
   logic is_beq;
   logic is_bne;
   logic is_jr;
   logic is_j;

   always_comb begin
      id_ctl = CTL_NOP;
      sext   = 1'b0;
      regrt  = 1'b0;
      use_rs = 1'b0;
      use_rt = 1'b0;
      is_beq = 1'b0;
      is_bne = 1'b0;
      is_jr  = 1'b0;
      is_j   = 1'b0;
      case (op)
         OP_RTYPE: begin
            use_rt = 1'b1;
            case (fn)
               FN_ADD: begin
                  id_ctl.aluc = ALU_ADD;
                  id_ctl.wreg = 1'b1;
                  use_rs      = 1'b1;
               end
               FN_SUB: begin
                  id_ctl.aluc = ALU_SUB;
                  id_ctl.wreg = 1'b1;
                  use_rs      = 1'b1;
               end
               FN_AND: begin
                  id_ctl.aluc = ALU_AND;
                  id_ctl.wreg = 1'b1;
                  use_rs      = 1'b1;
               end
               FN_OR: begin
                  id_ctl.aluc = ALU_OR;
                  id_ctl.wreg = 1'b1;
                  use_rs      = 1'b1;
               end
               FN_XOR: begin
                  id_ctl.aluc = ALU_XOR;
                  id_ctl.wreg = 1'b1;
                  use_rs      = 1'b1;
               end
               FN_SLL: begin
                  id_ctl.aluc  = ALU_SLL;
                  id_ctl.shift = 1'b1;
                  id_ctl.wreg  = 1'b1;
               end
               FN_SRL: begin
                  id_ctl.aluc  = ALU_SRL;
                  id_ctl.shift = 1'b1;
                  id_ctl.wreg  = 1'b1;
               end
               FN_SRA: begin
                  id_ctl.aluc  = ALU_SRA;
                  id_ctl.shift = 1'b1;
                  id_ctl.wreg  = 1'b1;
               end
               FN_JR: begin
                  use_rs = 1'b1;
                  is_jr  = 1'b1;
               end
               default: use_rt = 1'b0;
            endcase
         end
         OP_ADDI: begin
            id_ctl.aluc   = ALU_ADD;
            id_ctl.aluimm = 1'b1;
            id_ctl.wreg   = 1'b1;
            sext          = 1'b1;
            regrt         = 1'b1;
            use_rs        = 1'b1;
         end
         OP_ANDI: begin
            id_ctl.aluc   = ALU_AND;
            id_ctl.aluimm = 1'b1;
            id_ctl.wreg   = 1'b1;
            regrt         = 1'b1;
            use_rs        = 1'b1;
         end
         OP_ORI: begin
            id_ctl.aluc   = ALU_OR;
            id_ctl.aluimm = 1'b1;
            id_ctl.wreg   = 1'b1;
            regrt         = 1'b1;
            use_rs        = 1'b1;
         end
         OP_XORI: begin
            id_ctl.aluc   = ALU_XOR;
            id_ctl.aluimm = 1'b1;
            id_ctl.wreg   = 1'b1;
            regrt         = 1'b1;
            use_rs        = 1'b1;
         end
         OP_LUI: begin
            id_ctl.aluc   = ALU_LUI;
            id_ctl.aluimm = 1'b1;
            id_ctl.wreg   = 1'b1;
            regrt         = 1'b1;
         end
         OP_LW: begin
            id_ctl.aluimm = 1'b1;
            id_ctl.wreg   = 1'b1;
            id_ctl.m2reg  = 1'b1;
            sext          = 1'b1;
            regrt         = 1'b1;
            use_rs        = 1'b1;
         end
         OP_SW: begin
            id_ctl.aluimm = 1'b1;
            id_ctl.wmem   = 1'b1;
            sext          = 1'b1;
            regrt         = 1'b1;
            use_rs        = 1'b1;
            use_rt        = 1'b1;
         end
         OP_BEQ: begin
            sext   = 1'b1;
            regrt  = 1'b1;
            use_rs = 1'b1;
            use_rt = 1'b1;
            is_beq = 1'b1;
         end
         OP_BNE: begin
            sext   = 1'b1;
            regrt  = 1'b1;
            use_rs = 1'b1;
            use_rt = 1'b1;
            is_bne = 1'b1;
         end
         OP_J: is_j = 1'b1;
         OP_JAL: begin
            id_ctl.jal  = 1'b1;
            id_ctl.wreg = 1'b1;
            is_j        = 1'b1;
         end
         default: ;
      endcase
   end

   fb_t fbk;

   always_comb begin
      fbk        = '0;
      fbk.ern    = ern;
      fbk.ewreg  = ewreg_fb;
      fbk.em2reg = em2reg_fb;
      fbk.ealu   = ealu;
      fbk.mrn    = mrn;
      fbk.mwreg  = mwreg;
      fbk.mm2reg = mm2reg;
      fbk.malu   = malu;
      fbk.mmo    = mmo;
   end

   logic [31:0] fwd_a;
   logic [31:0] fwd_b;

   pipe_fwd_sel u_fwd_a (
      .src_i (rs),
      .q_i   (qa),
      .fb_i  (fbk),
      .val_o (fwd_a)
   );

   pipe_fwd_sel u_fwd_b (
      .src_i (rt),
      .q_i   (qb),
      .fb_i  (fbk),
      .val_o (fwd_b)
   );

   logic ld_in_ex;
   logic stall;
   logic equ;

   assign ld_in_ex = ewreg_fb & em2reg_fb & (ern != 5'd0);
   assign stall    = ld_in_ex
                   & ((use_rs & (ern == rs))
                   |  (use_rt & (ern == rt)));
   assign wpcir    = ~stall;
   assign equ      = (fwd_a == fwd_b);

   // The branch compare may use a not-yet-loaded value while
   // stalled, so no redirect until the stall clears.
   always_comb begin
      pcsource = 2'b00;
      if (!stall) begin
         if ((is_beq & equ) | (is_bne & ~equ)) begin
            pcsource = 2'b01;
         end else if (is_jr) begin
            pcsource = 2'b10;
         end else if (is_j) begin
            pcsource = 2'b11;
         end
      end
   end

   logic [31:0] imm_x;

   assign imm_x = ext16(imm16, sext);
   assign bpc   = dpc4 + PCW'({imm_x[29:0], 2'b00});
   assign rpc   = fwd_a[PCW-1:0];

   generate
      if (PCW > 28) begin : g_jwide
         assign jpc = {dpc4[PCW-1:28], dinst[25:0], 2'b00};
      end else begin : g_jnarrow
         assign jpc = PCW'({dinst[25:0], 2'b00});
      end
   endgenerate

   id_ex_t         id_ex_d;
   id_ex_t         id_ex_q;
   logic [PCW-1:0] epc4_q;

   always_comb begin
      id_ex_d     = '0;
      id_ex_d.ctl = stall ? CTL_NOP : id_ctl;
      id_ex_d.a   = fwd_a;
      id_ex_d.b   = fwd_b;
      id_ex_d.imm = imm_x;
      id_ex_d.sa  = sa;
      id_ex_d.rn0 = regrt ? rt : rd;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         id_ex_q <= '0;
         epc4_q  <= '0;
      end else begin
         id_ex_q <= id_ex_d;
         epc4_q  <= dpc4;
      end
   end

   assign ealuc   = id_ex_q.ctl.aluc;
   assign ealuimm = id_ex_q.ctl.aluimm;
   assign eshift  = id_ex_q.ctl.shift;
   assign ejal    = id_ex_q.ctl.jal;
   assign ewreg   = id_ex_q.ctl.wreg;
   assign em2reg  = id_ex_q.ctl.m2reg;
   assign ewmem   = id_ex_q.ctl.wmem;
   assign ea      = id_ex_q.a;
   assign eb      = id_ex_q.b;
   assign eimm    = id_ex_q.imm;
   assign esa     = id_ex_q.sa;
   assign ern0    = id_ex_q.rn0;
   assign epc4    = epc4_q;

endmodule
